// File: rtl/instruction_memory.sv
// instruction_memory: word-addressed instruction store with combinational fetch and a synchronous load port.
// Optional macro IMEM_REG_OUT_EN registers instruction and addr_oob for one-cycle fetch latency.
module instruction_memory #(
    parameter int L = 16,
    parameter int DEPTH = 64,
    parameter logic [L-1:0] NOP_WORD = 16'h0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [L-1:0] address,
    output logic [L-1:0] instruction,
    output logic         addr_oob,
    input  logic         wr_en,
    input  logic [L-1:0] wr_addr,
    input  logic [L-1:0] wr_data,
    output logic         wr_err
);
    localparam int AW = $clog2(DEPTH);
    logic [L-1:0] mem [DEPTH];
    logic [L-1:0] rd_word;
    logic         rd_oob;
    logic         wr_oob;
    assign rd_oob  = 32'(address) >= DEPTH;
    assign wr_oob  = 32'(wr_addr) >= DEPTH;
    assign rd_word = rd_oob ? NOP_WORD : mem[address[AW-1:0]];
    // Out-of-range writes are dropped rather than aliased onto the low addresses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_WORD;
            wr_err <= 1'b0;
        end else begin
            if (wr_en && !wr_oob) mem[wr_addr[AW-1:0]] <= wr_data;
            wr_err <= wr_en & wr_oob;
        end
    end
`ifdef IMEM_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction <= NOP_WORD;
            addr_oob    <= 1'b0;
        end else begin
            instruction <= rd_word;
            addr_oob    <= rd_oob;
        end
    end
`else
    assign instruction = rd_word;
    assign addr_oob    = rd_oob;
`endif
endmodule

// File: tb/tb_instruction_memory.sv
// tb_instruction_memory: directed self-checking bench for instruction_memory, combinational or registered read.
module tb_instruction_memory;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] instruction;
    logic        addr_oob;
    logic        wr_en = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_err;
    int vectors = 0;
    int miscompares = 0;

    instruction_memory dut (
        .clk(clk), .rst_n(rst_n), .address(address), .instruction(instruction),
        .addr_oob(addr_oob), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    // Wait until a freshly presented address is visible on the read outputs.
    task automatic settle();
`ifdef IMEM_REG_OUT_EN
        @(posedge clk); #1;
`else
        #1;
`endif
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if (instruction !== 16'h0000) begin
            miscompares++; $display("FAIL reset_instr got %h exp 0000", instruction);
        end
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++; $display("FAIL reset_wr_err got %b exp 0", wr_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int a = 0; a < 40; a++) begin
            address = 16'(a);
            settle();
            vectors++;
            if (instruction !== 16'h0000 || addr_oob !== 1'b0) begin
                miscompares++; $display("FAIL reset_sweep a=%0d got %h/%b exp 0000/0", a, instruction, addr_oob);
            end
        end
    endtask

    task automatic test_load();
        for (int a = 0; a < 40; a++) write_word(16'(a), 16'hA000 + 16'(a));
        for (int a = 0; a < 40; a++) begin
            address = 16'(a);
            settle();
            vectors++;
            if (instruction !== 16'hA000 + 16'(a) || addr_oob !== 1'b0) begin
                miscompares++;
                $display("FAIL load_sweep a=%0d got %h/%b exp %h/0", a, instruction, addr_oob, 16'hA000 + 16'(a));
            end
        end
    endtask

    task automatic test_boundary();
        write_word(16'd63, 16'h1234);
        address = 16'd63;
        settle();
        vectors++;
        if (instruction !== 16'h1234 || addr_oob !== 1'b0) begin
            miscompares++; $display("FAIL bound_63 got %h/%b exp 1234/0", instruction, addr_oob);
        end
        address = 16'd64;
        settle();
        vectors++;
        if (instruction !== 16'h0000 || addr_oob !== 1'b1) begin
            miscompares++; $display("FAIL bound_64 got %h/%b exp 0000/1", instruction, addr_oob);
        end
        address = 16'hFFFF;
        settle();
        vectors++;
        if (instruction !== 16'h0000 || addr_oob !== 1'b1) begin
            miscompares++; $display("FAIL bound_ffff got %h/%b exp 0000/1", instruction, addr_oob);
        end
    endtask

    task automatic test_oob_write();
        write_word(16'd100, 16'hFFFF);
        vectors++;
        if (wr_err !== 1'b1) begin
            miscompares++; $display("FAIL oob_wr_err_set got %b exp 1", wr_err);
        end
        @(posedge clk); #1;
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++; $display("FAIL oob_wr_err_clear got %b exp 0", wr_err);
        end
        write_word(16'd7, 16'hA007);
        vectors++;
        if (wr_err !== 1'b0) begin
            miscompares++; $display("FAIL inrange_wr_err got %b exp 0", wr_err);
        end
        address = 16'd36;
        settle();
        vectors++;
        if (instruction !== 16'hA024) begin
            miscompares++; $display("FAIL oob_no_alias got %h exp a024", instruction);
        end
    endtask

    task automatic test_read_during_write();
        address = 16'd5;
        settle();
        vectors++;
        if (instruction !== 16'hA005) begin
            miscompares++; $display("FAIL rdw_before got %h exp a005", instruction);
        end
        wr_en = 1'b1; wr_addr = 16'd5; wr_data = 16'h5555;
        #1;
        vectors++;
        if (instruction !== 16'hA005) begin
            miscompares++; $display("FAIL rdw_pre_edge got %h exp a005", instruction);
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
`ifdef IMEM_REG_OUT_EN
        vectors++;
        if (instruction !== 16'hA005) begin
            miscompares++; $display("FAIL rdw_write_edge got %h exp a005", instruction);
        end
        @(posedge clk); #1;
`endif
        vectors++;
        if (instruction !== 16'h5555) begin
            miscompares++; $display("FAIL rdw_after got %h exp 5555", instruction);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (instruction !== 16'h0000) begin
            miscompares++; $display("FAIL async_reset_instr got %h exp 0000", instruction);
        end
        wr_en = 1'b1; wr_addr = 16'd5; wr_data = 16'hBEEF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        vectors++;
        if (wr_err !== 1'b0 || instruction !== 16'h0000) begin
            miscompares++; $display("FAIL reset_write_ignored got %b/%h exp 0/0000", wr_err, instruction);
        end
        rst_n = 1'b1;
        settle();
        vectors++;
        if (instruction !== 16'h0000) begin
            miscompares++; $display("FAIL post_reset_a5 got %h exp 0000", instruction);
        end
        address = 16'd0;
        settle();
        vectors++;
        if (instruction !== 16'h0000) begin
            miscompares++; $display("FAIL post_reset_a0 got %h exp 0000", instruction);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_boundary();
        test_oob_write();
        test_read_during_write();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
